pipeline_flow_ctrl: RTL
=======================

// Module: pipeline_flow_ctrl
// PURPOSE
//  Pipeline sequencer and hazard controller for the 5-stage MIPS core.
//  Sits beside the ID stage. Consumes decoded-instruction flags plus EX-stage load info.
//  Generates PC/IF-ID enables, IF-ID flush and ID-EX bubble.
//  Run/step/halt FSM is driven by the debug unit through a valid/ready command port.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles the EX/MEM/WB stages keep running after a HALT reaches ID
//  CNT_W         32  width of the cycle counter (optional feature)
// PORTS
//  i_clk          in   1   clock; all state updates on rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_cmd_valid    in   1   debug command valid
//  i_cmd          in   2   00 nop, 01 run, 10 step, 11 halt
//  o_cmd_ready    out  1   command accepted this cycle when valid&ready
//  i_id_rs        in   5   ID source reg rs (decoder o_rs)
//  i_id_rt        in   5   ID source reg rt (decoder o_rt)
//  i_id_pc_modify in   1   ID instruction is jump/branch (decoder o_flg_pc_modify)
//  i_id_br_taken  in   1   branch/jump resolved taken in ID
//  i_id_halt      in   1   ID holds HALT opcode
//  i_ex_mem_op    in   1   EX instruction is memory op
//  i_ex_mem_type  in   1   EX mem type: 0 load, 1 store
//  i_ex_rt        in   5   EX destination rt
//  o_pc_en        out  1   PC update enable
//  o_ifid_en      out  1   IF/ID register enable
//  o_ifid_flush   out  1   IF/ID loaded with NOP
//  o_idex_bubble  out  1   ID/EX loaded with NOP
//  o_back_en      out  1   EX/MEM/WB register enable
//  o_state        out  3   FSM state encoding (registered)
//  o_done         out  1   program finished (registered)
//  o_cycle_cnt    out  CNT_W  cycles advanced (only with PIPE_CYCLE_CNT_EN)
// BEHAVIOUR
//  FSM states: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. Reset -> IDLE.
//  Reset values: o_state=0, o_done=0, o_cycle_cnt=0, drain counter=0.
//  Combinational outputs are 0 in IDLE/DONE.
//  Transitions:
//  - IDLE: run -> RUN; step -> STEP; halt/nop -> stay IDLE.
//  - RUN: halt cmd -> IDLE after the current cycle; i_id_halt -> DRAIN.
//  - STEP: advances exactly one cycle, then IDLE. If i_id_halt is seen in that cycle, go to DRAIN instead.
//  - DRAIN: o_pc_en=0, o_ifid_en=0, o_idex_bubble=1, o_back_en=1.
//    Runs DRAIN_CYCLES cycles, then DONE. Halt/step/run commands are ignored.
//  - DONE: sticky until reset; o_done=1.
//  o_cmd_ready: 1 in IDLE; 1 in RUN (halt only); 0 in STEP/DRAIN/DONE.
//   In RUN, a run/step command with valid is not accepted (ready is effectively 0 for it).
//  Advancing = state RUN or STEP. When advancing:
//  - load_use = i_ex_mem_op & ~i_ex_mem_type & (i_ex_rt!=0)
//    & (i_ex_rt==i_id_rs | i_ex_rt==i_id_rt).
//  - load_use=1: o_pc_en=0, o_ifid_en=0, o_idex_bubble=1, o_back_en=1, o_ifid_flush=0.
//  - else: o_pc_en=1, o_ifid_en=1, o_back_en=1.
//    o_ifid_flush = i_id_pc_modify & i_id_br_taken.
//  - load_use and taken branch together: stall wins. Flush is suppressed and re-evaluated next cycle.
//  - i_id_halt while advancing: o_pc_en=0, o_ifid_flush=1, o_idex_bubble=1, o_back_en=1. Enter DRAIN.
//    HALT is never passed to EX.
//  - A STEP cycle that stalls still counts as the single step.
//  Latency: hazard outputs are same-cycle combinational. Command-to-first-advance is 1 cycle.
//  Reset mid-DRAIN or mid-STEP: immediate return to IDLE. Drain counter is cleared.
// CONFIGURATION
//  PIPE_CYCLE_CNT_EN defined:
//  - o_cycle_cnt increments on every cycle with o_back_en=1.
//  - Wraps at 2^CNT_W-1 -> 0. Freezes in DONE. Cleared only by reset.
//  Not defined: o_cycle_cnt port is absent and no counter logic is generated.
// TESTING
//  T1: reset low mid-RUN -> all outputs 0, o_state=0, o_done=0 while reset is asserted.
//  T2: IDLE, cmd=10 valid -> exactly one cycle with o_pc_en=1, then o_state=0 and o_pc_en=0.
//  T3: RUN, ex load rt=5, id rs=5 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1.
//      Repeat with i_ex_rt=0 -> no stall.
//  T4: RUN, br_taken=1 with pc_modify=1 and no hazard -> ifid_flush=1.
//      Same with load_use=1 -> ifid_flush=0, stall=1.
//  T5: RUN, i_id_halt=1 -> DRAIN for 3 cycles (back_en=1, pc_en=0), then o_done=1 and all enables 0.
//      cmd=01 in DONE -> ready=0.
//  T6 (PIPE_CYCLE_CNT_EN, CNT_W=4): 17 advancing cycles -> o_cycle_cnt=1 (wrap).

Source files
------------

// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: run/step/halt sequencer and load-use/branch/halt hazard control beside ID (PIPE_CYCLE_CNT_EN adds o_cycle_cnt).
// Latency: hazard outputs are combinational in the same cycle; an accepted command advances the pipe from the next cycle.
// Backpressure: o_cmd_ready is high in IDLE, high for halt only in RUN, low in STEP/DRAIN/DONE and while in reset.
module pipeline_flow_ctrl #(
    parameter int DRAIN_CYCLES = 3
`ifdef PIPE_CYCLE_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
    output logic       o_cmd_ready,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_pc_modify,
    input  logic       i_id_br_taken,
    input  logic       i_id_halt,
    input  logic       i_ex_mem_op,
    input  logic       i_ex_mem_type,
    input  logic [4:0] i_ex_rt,
    output logic       o_pc_en,
    output logic       o_ifid_en,
    output logic       o_ifid_flush,
    output logic       o_idex_bubble,
    output logic       o_back_en,
    output logic [2:0] o_state,
    output logic       o_done
`ifdef PIPE_CYCLE_CNT_EN
    , output logic [CNT_W-1:0] o_cycle_cnt
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [DW-1:0] r_drain_cnt;
    logic [DW-1:0] w_drain_nxt;
    logic          r_done;
    logic          w_adv;
    logic          w_load_use;
    logic          w_cmd_acc;

    assign w_adv      = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_load_use = i_ex_mem_op & ~i_ex_mem_type & (i_ex_rt != 5'd0)
                      & ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
    assign w_cmd_acc  = i_cmd_valid & o_cmd_ready;

    assign o_state = r_state;
    assign o_done  = r_done;

    // Gated by reset so nothing looks accepted while the block is held in reset.
    assign o_cmd_ready = i_rst_n & ((r_state == ST_IDLE) |
                                    ((r_state == ST_RUN) & (i_cmd == CMD_HALT)));

    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_back_en     = 1'b0;
        if (w_adv) begin
            o_back_en = 1'b1;
            if (i_id_halt) begin
                // HALT is squashed here so it never reaches EX.
                o_ifid_flush  = 1'b1;
                o_idex_bubble = 1'b1;
            end else if (w_load_use) begin
                o_idex_bubble = 1'b1;
            end else begin
                o_pc_en      = 1'b1;
                o_ifid_en    = 1'b1;
                o_ifid_flush = i_id_pc_modify & i_id_br_taken;
            end
        end else if (r_state == ST_DRAIN) begin
            o_idex_bubble = 1'b1;
            o_back_en     = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc && (i_cmd == CMD_RUN)) begin
                    w_state_nxt = ST_RUN;
                end else if (w_cmd_acc && (i_cmd == CMD_STEP)) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_id_halt) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_cmd_acc) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                // A stalled step still consumes the step.
                w_state_nxt = i_id_halt ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drain_nxt = r_drain_cnt + DW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_done      <= r_done | (w_state_nxt == ST_DONE);
        end
    end

`ifdef PIPE_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    // o_back_en is low in DONE, so the count freezes there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
        end else if (o_back_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`endif

endmodule
